score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Upstream of the two digital_ssd score digits in the pong top level.
- Detects point events from the ball logic, keeps per-player scores 0..WIN_SCORE, and sequences serve, play and game-over.
- Drives each digit's Value (4 bits) and colour byte (RRRGGGBB).
- Gates the ball with ball_enable and serve_dir.

Parameters:
- WIN_SCORE, 9, score that ends the game; legal range 1..9.
- SERVE_DELAY, 64, number of tick strobes spent in SERVE before the ball is released; must be >= 1.
- FLASH_PERIOD, 16, number of tick strobes per half-period of the winner-digit flash.
- BASE_COLOR, 8'hFF, normal digit colour (white).
- FLASH_COLOR, 8'hE0, alternate colour for the winning digit (red).

Ports:
- board_clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle game-rate strobe from the clock divider
- start  in  1  new-game request, level; rising edge acts
- left_point  in  1  left player scored; level, may last many cycles
- right_point  in  1  right player scored; level, may last many cycles
- left_value  out  4  left score, to digital_ssd Value
- right_value  out  4  right score, to digital_ssd Value
- left_color  out  8  left digit colour
- right_color  out  8  right digit colour
- ball_enable  out  1  1 = ball may move
- serve_dir  out  1  1 = serve toward the right player, 0 = toward the left player
- game_over  out  1  game finished
- winner  out  1  0 = left won, 1 = right won; valid while game_over = 1

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock board_clk. Every register and every output is clocked on the board_clk rising edge.
- Reset values:
  - state = IDLE.
  - Both values = 0; both colours = BASE_COLOR.
  - ball_enable = 0, serve_dir = 0, game_over = 0, winner = 0.
  - Delay and flash counters = 0; edge-detect registers = 0.
- Edge detection:
  - start, left_point and right_point each have a previous-value register.
  - An event is input = 1 while its previous-value register = 0.
  - Outputs reflect the event at the same board_clk edge the event is sampled, i.e. one cycle of latency from the input change.
  - A level held high produces exactly one event.
- State machine (IDLE, SERVE, PLAY, GAME_OVER):
  - IDLE: ball_enable = 0; point events are ignored. A start event goes to SERVE.
  - start event in any state:
    - Clears both scores and the delay counter and sets serve_dir = 0.
    - Clears game_over and winner; restores both colours to BASE_COLOR.
    - Sets ball_enable = 0 and goes to SERVE.
    - start takes priority over a simultaneous point event.
  - SERVE:
    - ball_enable = 0; the delay counter increments on each tick.
    - A tick in the cycle of entry into SERVE is not counted.
    - When the counter reaches SERVE_DELAY: go to PLAY, ball_enable = 1, counter cleared.
    - Point events are ignored.
  - PLAY, left event only:
    - left_value += 1; serve_dir = 1; ball_enable = 0.
    - If the new value == WIN_SCORE: go to GAME_OVER with winner = 0 and game_over = 1. Otherwise go to SERVE.
  - PLAY, right event only: mirror of the left case (right_value += 1, serve_dir = 0, winner = 1).
  - PLAY, simultaneous left and right events: no score change, serve_dir unchanged, ball_enable = 0, go to SERVE (replay).
  - GAME_OVER:
    - ball_enable = 0; point events are ignored.
    - The flash counter increments on each tick. At FLASH_PERIOD it wraps to 0 and toggles the winner's colour between BASE_COLOR and FLASH_COLOR.
    - The winner's colour is FLASH_COLOR for the first half-period. The loser's colour stays BASE_COLOR.
    - Exit only on a start event.
- Width and arithmetic rules:
  - Scores never exceed WIN_SCORE, and the upper value bits are 0.
  - No wrap to 0 except via start or reset.
- Reset mid-operation (e.g. during SERVE countdown or GAME_OVER flash): immediate return to reset values, including asynchronous deassertion of ball_enable.
- tick and events in the same cycle: both are processed independently. A tick that coincides with a transition out of SERVE does not carry over into the next counter.

Test Plan:
- Reset, then start pulse → SERVE. After exactly 64 ticks ball_enable = 1 and both values = 0. With only 63 ticks, ball_enable is still 0.
- In PLAY, left_point held high for 50 cycles → left_value = 1 (single increment), serve_dir = 1, ball_enable = 0, re-released after 64 ticks.
- left_point and right_point rise in the same cycle during PLAY → scores unchanged, state SERVE, serve_dir retains its prior value.
- Right scores 9 times → right_value = 9, game_over = 1, winner = 1. right_color alternates 8'hE0 / 8'hFF every 16 ticks, left_color stays 8'hFF, and further point pulses are ignored.
- In GAME_OVER, a start pulse → values = 0/0, game_over = 0, both colours = 8'hFF, SERVE entered.
- Assert reset during the SERVE countdown at tick 30 → all outputs return to reset values immediately. A start pulse after release then needs the full 64 ticks.

Source files
------------

// File: rtl/score_keeper_if.sv
// Point/start inputs and score-digit/ball-control outputs of score_keeper.
// Master is the pong top level, slave is score_keeper.
interface score_keeper_if;
   logic       tick;
   logic       start;
   logic       left_point;
   logic       right_point;
   logic [3:0] left_value;
   logic [3:0] right_value;
   logic [7:0] left_color;
   logic [7:0] right_color;
   logic       ball_enable;
   logic       serve_dir;
   logic       game_over;
   logic       winner;

   modport master (
      output tick, start, left_point, right_point,
      input  left_value, right_value,
      input  left_color, right_color,
      input  ball_enable, serve_dir,
      input  game_over, winner
   );

   modport slave (
      input  tick, start, left_point, right_point,
      output left_value, right_value,
      output left_color, right_color,
      output ball_enable, serve_dir,
      output game_over, winner
   );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: point edge detect, serve/play/game-over sequencing,
// score digit values and winner-flash colours.
module score_keeper #(
   parameter int         WIN_SCORE    = 9,
   parameter int         SERVE_DELAY  = 64,
   parameter int         FLASH_PERIOD = 16,
   parameter logic [7:0] BASE_COLOR   = 8'hFF,
   parameter logic [7:0] FLASH_COLOR  = 8'hE0
) (
   input logic          board_clk,
   input logic          reset,
   score_keeper_if.slave sk
);

   localparam int DW = $clog2(SERVE_DELAY + 1);
   localparam int FW = $clog2(FLASH_PERIOD + 1);

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      PLAY,
      GAME_OVER
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    lval_q, lval_d;
   logic [3:0]    rval_q, rval_d;
   logic [7:0]    lcol_q, lcol_d;
   logic [7:0]    rcol_q, rcol_d;
   logic          ben_q, ben_d;
   logic          sdir_q, sdir_d;
   logic          gover_q, gover_d;
   logic          win_q, win_d;
   logic          flash_q, flash_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          start_q, lpt_q, rpt_q;

   logic start_ev, lev, rev;
   logic [3:0] lval_inc, rval_inc;
   logic [7:0] flash_col;

   assign start_ev = sk.start & ~start_q;
   assign lev      = sk.left_point & ~lpt_q;
   assign rev      = sk.right_point & ~rpt_q;
   assign lval_inc = lval_q + 4'd1;
   assign rval_inc = rval_q + 4'd1;
   assign flash_col = flash_d ? FLASH_COLOR : BASE_COLOR;

   always_comb begin
      state_d = state_q;
      lval_d  = lval_q;
      rval_d  = rval_q;
      lcol_d  = lcol_q;
      rcol_d  = rcol_q;
      ben_d   = ben_q;
      sdir_d  = sdir_q;
      gover_d = gover_q;
      win_d   = win_q;
      flash_d = flash_q;
      dcnt_d  = dcnt_q;
      fcnt_d  = fcnt_q;
      if (start_ev) begin
         state_d = SERVE;
         lval_d  = 4'd0;
         rval_d  = 4'd0;
         lcol_d  = BASE_COLOR;
         rcol_d  = BASE_COLOR;
         ben_d   = 1'b0;
         sdir_d  = 1'b0;
         gover_d = 1'b0;
         win_d   = 1'b0;
         flash_d = 1'b0;
         dcnt_d  = '0;
         fcnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: ben_d = 1'b0;
            SERVE: begin
               ben_d = 1'b0;
               if (sk.tick) begin
                  if (dcnt_q == DW'(SERVE_DELAY - 1)) begin
                     state_d = PLAY;
                     ben_d   = 1'b1;
                     dcnt_d  = '0;
                  end else begin
                     dcnt_d = dcnt_q + 1'b1;
                  end
               end
            end
            PLAY: begin
               unique case (1'b1)
                  lev & rev: begin
                     ben_d   = 1'b0;
                     state_d = SERVE;
                  end
                  lev & ~rev: begin
                     lval_d = lval_inc;
                     sdir_d = 1'b1;
                     ben_d  = 1'b0;
                     if (lval_inc == 4'(WIN_SCORE)) begin
                        state_d = GAME_OVER;
                        gover_d = 1'b1;
                        win_d   = 1'b0;
                        flash_d = 1'b1;
                        fcnt_d  = '0;
                        lcol_d  = FLASH_COLOR;
                     end else begin
                        state_d = SERVE;
                     end
                  end
                  rev & ~lev: begin
                     rval_d = rval_inc;
                     sdir_d = 1'b0;
                     ben_d  = 1'b0;
                     if (rval_inc == 4'(WIN_SCORE)) begin
                        state_d = GAME_OVER;
                        gover_d = 1'b1;
                        win_d   = 1'b1;
                        flash_d = 1'b1;
                        fcnt_d  = '0;
                        rcol_d  = FLASH_COLOR;
                     end else begin
                        state_d = SERVE;
                     end
                  end
                  default: ;
               endcase
            end
            GAME_OVER: begin
               ben_d = 1'b0;
               if (sk.tick) begin
                  if (fcnt_q == FW'(FLASH_PERIOD - 1)) begin
                     fcnt_d  = '0;
                     flash_d = ~flash_q;
                  end else begin
                     fcnt_d = fcnt_q + 1'b1;
                  end
               end
               // Only the winner's digit follows the flash phase
               if (win_q) rcol_d = flash_col;
               else       lcol_d = flash_col;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         lval_q  <= 4'd0;
         rval_q  <= 4'd0;
         lcol_q  <= BASE_COLOR;
         rcol_q  <= BASE_COLOR;
         ben_q   <= 1'b0;
         sdir_q  <= 1'b0;
         gover_q <= 1'b0;
         win_q   <= 1'b0;
         flash_q <= 1'b0;
         dcnt_q  <= '0;
         fcnt_q  <= '0;
         start_q <= 1'b0;
         lpt_q   <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lval_q  <= lval_d;
         rval_q  <= rval_d;
         lcol_q  <= lcol_d;
         rcol_q  <= rcol_d;
         ben_q   <= ben_d;
         sdir_q  <= sdir_d;
         gover_q <= gover_d;
         win_q   <= win_d;
         flash_q <= flash_d;
         dcnt_q  <= dcnt_d;
         fcnt_q  <= fcnt_d;
         start_q <= sk.start;
         lpt_q   <= sk.left_point;
         rpt_q   <= sk.right_point;
      end
   end

   assign sk.left_value  = lval_q;
   assign sk.right_value = rval_q;
   assign sk.left_color  = lcol_q;
   assign sk.right_color = rcol_q;
   assign sk.ball_enable = ben_q;
   assign sk.serve_dir   = sdir_q;
   assign sk.game_over   = gover_q;
   assign sk.winner      = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scenario bench for score_keeper: expected output snapshots are queued
// with the stimulus and popped when the outputs are sampled.
module tb_score_keeper;

   logic board_clk = 1'b0;
   logic reset = 1'b0;
   int tests = 0;
   int fails = 0;
   logic [27:0] exp_q[$];
   logic [27:0] e;
   logic [27:0] got;

   score_keeper_if sk();

   score_keeper dut (
      .board_clk(board_clk),
      .reset(reset),
      .sk(sk)
   );

   always #5 board_clk = ~board_clk;

   function automatic logic [27:0] pk(
      input logic [3:0] lv, input logic [3:0] rv,
      input logic [7:0] lc, input logic [7:0] rc,
      input logic ben, input logic sd,
      input logic go, input logic w);
      return {lv, rv, lc, rc, ben, sd, go, w};
   endfunction

   function automatic logic [27:0] obs();
      return {sk.left_value, sk.right_value,
              sk.left_color, sk.right_color,
              sk.ball_enable, sk.serve_dir,
              sk.game_over, sk.winner};
   endfunction

   task automatic step();
      @(posedge board_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sk.tick = 1'b1;
         step();
      end
      sk.tick = 1'b0;
   endtask

   task automatic test_reset();
      sk.tick = 0; sk.start = 0;
      sk.left_point = 0; sk.right_point = 0;
      step();
      reset = 1'b1;
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      #1;
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL reset: got %h expected %h", got, e);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_serve();
      sk.start = 1'b1;
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      step();
      sk.start = 1'b0;
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL serve_entry: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      ticks(63);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL serve_63: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0));
      ticks(1);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL serve_64: got %h expected %h", got, e);
      end
   endtask

   task automatic test_point_hold();
      sk.left_point = 1'b1;
      exp_q.push_back(pk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 0));
      step();
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL hold_first: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 0));
      for (int i = 0; i < 49; i++) step();
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL hold_50: got %h expected %h", got, e);
      end
      sk.left_point = 1'b0;
      step();
      exp_q.push_back(pk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 0));
      ticks(63);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL hold_serve63: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0));
      ticks(1);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL hold_serve64: got %h expected %h", got, e);
      end
   endtask

   task automatic test_simultaneous();
      sk.left_point = 1'b1;
      sk.right_point = 1'b1;
      exp_q.push_back(pk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 0));
      step();
      sk.left_point = 1'b0;
      sk.right_point = 1'b0;
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL simul_replay: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0));
      ticks(64);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL simul_reserve: got %h expected %h", got, e);
      end
   endtask

   task automatic test_game_over();
      for (int i = 1; i <= 8; i++) begin
         sk.right_point = 1'b1;
         step();
         sk.right_point = 1'b0;
         step();
         ticks(64);
      end
      exp_q.push_back(pk(1, 8, 8'hFF, 8'hFF, 1, 0, 0, 0));
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL right_8: got %h expected %h", got, e);
      end
      sk.right_point = 1'b1;
      exp_q.push_back(pk(1, 9, 8'hFF, 8'hE0, 0, 0, 1, 1));
      step();
      sk.right_point = 1'b0;
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL win_entry: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(1, 9, 8'hFF, 8'hE0, 0, 0, 1, 1));
      ticks(15);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL flash_15: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(1, 9, 8'hFF, 8'hFF, 0, 0, 1, 1));
      ticks(1);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL flash_16: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(1, 9, 8'hFF, 8'hE0, 0, 0, 1, 1));
      ticks(16);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL flash_32: got %h expected %h", got, e);
      end
      sk.left_point = 1'b1;
      step();
      sk.left_point = 1'b0;
      sk.right_point = 1'b1;
      step();
      sk.right_point = 1'b0;
      exp_q.push_back(pk(1, 9, 8'hFF, 8'hE0, 0, 0, 1, 1));
      step();
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL gameover_ignore: got %h expected %h", got, e);
      end
   endtask

   task automatic test_restart();
      sk.start = 1'b1;
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      step();
      sk.start = 1'b0;
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL restart: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0));
      ticks(64);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL restart_play: got %h expected %h", got, e);
      end
   endtask

   task automatic test_reset_mid();
      sk.right_point = 1'b1;
      step();
      sk.right_point = 1'b0;
      step();
      ticks(30);
      reset = 1'b1;
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      #1;
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL reset_mid: got %h expected %h", got, e);
      end
      #2;
      reset = 1'b0;
      step();
      sk.start = 1'b1;
      step();
      sk.start = 1'b0;
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      ticks(63);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL reset_mid_63: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0));
      ticks(1);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL reset_mid_64: got %h expected %h", got, e);
      end
   endtask

   task automatic test_tick_on_entry();
      sk.start = 1'b1;
      sk.tick = 1'b1;
      step();
      sk.start = 1'b0;
      sk.tick = 1'b0;
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0));
      ticks(63);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL entry_tick_63: got %h expected %h", got, e);
      end
      exp_q.push_back(pk(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0));
      ticks(1);
      got = obs(); e = exp_q.pop_front(); tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL entry_tick_64: got %h expected %h", got, e);
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_point_hold();
      test_simultaneous();
      test_game_over();
      test_restart();
      test_reset_mid();
      test_tick_on_entry();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
